// File: rtl/mem_bus_responder.sv
`default_nettype none
// ============================================================================
// mem_bus_responder : OR-bus memory target, read_q/write_q handshake, latched
// request, programmable read latency. Optional macro: WRITE_PROTECT_EN.
// Rev 1.0
// ============================================================================
module mem_bus_responder #(
  parameter int          ADDR_W   = 32,
  parameter int          DATA_W   = 32,
  parameter int          MEM_AW   = 8,
  parameter int unsigned BASE     = 0,
  parameter int          READ_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read_q,
  input  logic              write_q,
  input  logic [ADDR_W-1:0] addr_unmodificable_b,
  output logic [DATA_W-1:0] data_out,
  output logic              read_dn,
  output logic              write_dn,
  output logic              rw_halt_out,
  output logic              bus_busy_out
);

  localparam int                     c_depth  = 1 << MEM_AW;
  localparam logic [ADDR_W-MEM_AW-1:0] c_base = (ADDR_W-MEM_AW)'(BASE);
  localparam logic [3:0]             c_lat_m1 = 4'(READ_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_WAIT = 3'd1,
    S_RD_DONE = 3'd2,
    S_WRITE   = 3'd3,
    S_WR_DONE = 3'd4,
    S_HOLDOFF = 3'd5
  } state_t;

  state_t              r_state, w_state;
  logic [3:0]          r_cnt, w_cnt;
  logic [MEM_AW-1:0]   r_off, w_off;
  logic [DATA_W-1:0]   r_wdata, w_wdata;
  logic [DATA_W-1:0]   r_data_out, w_data_out;
  logic                r_read_dn, w_read_dn;
  logic                r_write_dn, w_write_dn;
  logic                r_busy, w_busy;
  logic                w_mem_we;
  logic                w_hit;
  logic                w_protected;
  logic [DATA_W-1:0]   w_rdata;
  logic [DATA_W-1:0]   r_mem [c_depth];

  assign w_hit = (addr_in[ADDR_W-1:MEM_AW] == c_base);

`ifdef WRITE_PROTECT_EN
  localparam logic [MEM_AW-1:0] c_prot_off = '1;
  logic r_prot_viol;

  // The latched address is rebuilt from the window base plus the local offset.
  assign w_protected = ({c_base, r_off} < addr_unmodificable_b);
  assign w_rdata     = (r_off == c_prot_off) ? DATA_W'(r_prot_viol) : r_mem[r_off];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_prot_viol <= 1'b0;
    end else if (r_state == S_WRITE && w_protected) begin
      r_prot_viol <= 1'b1;
    end
  end
`else
  logic unused_wp;
  assign unused_wp   = ^addr_unmodificable_b;
  assign w_protected = 1'b0;
  assign w_rdata     = r_mem[r_off];
`endif

  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_off      = r_off;
    w_wdata    = r_wdata;
    w_data_out = r_data_out;
    w_read_dn  = r_read_dn;
    w_write_dn = r_write_dn;
    w_busy     = r_busy;
    w_mem_we   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_hit && write_q) begin
          w_off   = addr_in[MEM_AW-1:0];
          w_wdata = data_in;
          w_busy  = 1'b1;
          w_state = S_WRITE;
        end else if (w_hit && read_q) begin
          w_off   = addr_in[MEM_AW-1:0];
          w_cnt   = c_lat_m1;
          w_busy  = 1'b1;
          w_state = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (!read_q) begin
          w_cnt   = 4'd0;
          w_busy  = 1'b0;
          w_state = S_HOLDOFF;
        end else if (r_cnt == 4'd0) begin
          w_data_out = w_rdata;
          w_read_dn  = 1'b1;
          w_state    = S_RD_DONE;
        end else begin
          w_cnt = r_cnt - 4'd1;
        end
      end
      S_RD_DONE: begin
        if (!read_q) begin
          w_data_out = '0;
          w_read_dn  = 1'b0;
          w_busy     = 1'b0;
          w_state    = S_HOLDOFF;
        end
      end
      S_WRITE: begin
        // Protected writes still complete the handshake; only the array update is suppressed.
        w_mem_we   = !w_protected;
        w_write_dn = 1'b1;
        w_state    = S_WR_DONE;
      end
      S_WR_DONE: begin
        if (!write_q) begin
          w_write_dn = 1'b0;
          w_busy     = 1'b0;
          w_state    = S_HOLDOFF;
        end
      end
      S_HOLDOFF: w_state = S_IDLE;
      default:   w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_off      <= '0;
      r_wdata    <= '0;
      r_data_out <= '0;
      r_read_dn  <= 1'b0;
      r_write_dn <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_off      <= w_off;
      r_wdata    <= w_wdata;
      r_data_out <= w_data_out;
      r_read_dn  <= w_read_dn;
      r_write_dn <= w_write_dn;
      r_busy     <= w_busy;
    end
  end

  // Array contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_off] <= r_wdata;
    end
  end

  assign data_out     = r_data_out;
  assign read_dn      = r_read_dn;
  assign write_dn     = r_write_dn;
  assign rw_halt_out  = r_busy;
  assign bus_busy_out = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_responder.sv
`default_nettype none
// Testbench for mem_bus_responder: directed scenarios plus randomized traffic
// checked against an array model of the responder's memory.
module tb_mem_bus_responder;

  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        rst_b;
  logic [31:0] addr_in;
  logic [31:0] data_in;
  logic        read_q;
  logic        write_q;
  logic [31:0] addr_unmodificable_b;
  logic [31:0] data_out;
  logic        read_dn;
  logic        write_dn;
  logic        rw_halt_out;
  logic        bus_busy_out;

  int total = 0;
  int bad   = 0;

  logic [31:0] model_mem [256];
  bit          written   [256];
  logic        model_prot = 1'b0;

  mem_bus_responder #(
    .ADDR_W(32), .DATA_W(32), .MEM_AW(8), .BASE(0), .READ_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst_b(rst_b), .addr_in(addr_in), .data_in(data_in),
    .read_q(read_q), .write_q(write_q),
    .addr_unmodificable_b(addr_unmodificable_b),
    .data_out(data_out), .read_dn(read_dn), .write_dn(write_dn),
    .rw_halt_out(rw_halt_out), .bus_busy_out(bus_busy_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] off, input logic [31:0] d,
                          input logic also_read, input int hold);
    bit commit;
    commit = 1'b1;
`ifdef WRITE_PROTECT_EN
    commit = ({24'h0, off} >= addr_unmodificable_b);
`endif
    addr_in = {24'h0, off};
    data_in = d;
    write_q = 1'b1;
    read_q  = also_read;
    tick();
    total++;
    if (rw_halt_out !== 1'b1 || bus_busy_out !== 1'b1 || write_dn !== 1'b0) begin
      bad++;
      $display("FAIL wr_accept off=%h halt=%b busy=%b wdn=%b required 1 1 0", off, rw_halt_out, bus_busy_out, write_dn);
    end
    addr_in = $urandom;
    data_in = $urandom;
    tick();
    if (commit) begin
      model_mem[off] = d;
      written[off]   = 1'b1;
    end else begin
      model_prot = 1'b1;
    end
    total++;
    if (write_dn !== 1'b1 || read_dn !== 1'b0 || data_out !== 32'h0) begin
      bad++;
      $display("FAIL wr_done off=%h wdn=%b rdn=%b dout=%h required 1 0 0", off, write_dn, read_dn, data_out);
    end
    for (int i = 0; i < hold; i++) begin
      tick();
      total++;
      if (write_dn !== 1'b1) begin
        bad++;
        $display("FAIL wr_hold off=%h wdn=%b required 1", off, write_dn);
      end
    end
    write_q = 1'b0;
    read_q  = 1'b0;
    tick();
    total++;
    if (write_dn !== 1'b0 || rw_halt_out !== 1'b0 || bus_busy_out !== 1'b0) begin
      bad++;
      $display("FAIL wr_release off=%h wdn=%b halt=%b busy=%b required 0 0 0", off, write_dn, rw_halt_out, bus_busy_out);
    end
    tick();
  endtask

  task automatic do_read(input logic [7:0] off, input int hold);
    logic [31:0] exp;
    int n;
    exp = model_mem[off];
`ifdef WRITE_PROTECT_EN
    if (off == 8'hFF) exp = {31'h0, model_prot};
`endif
    addr_in = {24'h0, off};
    read_q  = 1'b1;
    tick();
    total++;
    if (bus_busy_out !== 1'b1 || read_dn !== 1'b0) begin
      bad++;
      $display("FAIL rd_accept off=%h busy=%b rdn=%b required 1 0", off, bus_busy_out, read_dn);
    end
    addr_in = $urandom;
    n = 0;
    while (read_dn !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (n != RD_LAT) begin
      bad++;
      $display("FAIL rd_latency off=%h cycles=%0d required %0d", off, n, RD_LAT);
    end
    total++;
    if (data_out !== exp) begin
      bad++;
      $display("FAIL rd_data off=%h got=%h required %h", off, data_out, exp);
    end
    for (int i = 0; i < hold; i++) tick();
    total++;
    if (read_dn !== 1'b1 || data_out !== exp) begin
      bad++;
      $display("FAIL rd_hold off=%h rdn=%b dout=%h required 1 %h", off, read_dn, data_out, exp);
    end
    read_q = 1'b0;
    tick();
    total++;
    if (read_dn !== 1'b0 || data_out !== 32'h0 || bus_busy_out !== 1'b0) begin
      bad++;
      $display("FAIL rd_release off=%h rdn=%b dout=%h busy=%b required 0 0 0", off, read_dn, data_out, bus_busy_out);
    end
    tick();
  endtask

  task automatic test_reset();
    rst_b   = 1'b0;
    read_q  = 1'b1;
    write_q = 1'b0;
    addr_in = 32'h10;
    data_in = 32'h0;
    addr_unmodificable_b = 32'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({data_out, read_dn, write_dn, rw_halt_out, bus_busy_out} !== 36'h0) begin
        bad++;
        $display("FAIL reset_outputs cyc=%0d dout=%h rdn=%b wdn=%b halt=%b busy=%b required all 0", i, data_out, read_dn, write_dn, rw_halt_out, bus_busy_out);
      end
    end
    addr_in = 32'h0000_0110;
    write_q = 1'b1;
    rst_b   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if ({data_out, read_dn, write_dn, rw_halt_out, bus_busy_out} !== 36'h0) begin
        bad++;
        $display("FAIL nohit_outputs cyc=%0d dout=%h rdn=%b wdn=%b busy=%b required all 0", i, data_out, read_dn, write_dn, bus_busy_out);
      end
    end
    read_q  = 1'b0;
    write_q = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    do_write(8'h10, 32'hDEADBEEF, 1'b0, 2);
    do_read(8'h10, 1);
  endtask

  task automatic test_simultaneous();
    do_write(8'h20, 32'h5, 1'b1, 1);
    do_read(8'h20, 0);
  endtask

  task automatic test_abort();
    addr_in = 32'h10;
    read_q  = 1'b1;
    tick();
    read_q = 1'b0;
    for (int i = 0; i < RD_LAT + 2; i++) begin
      tick();
      total++;
      if (read_dn !== 1'b0 || data_out !== 32'h0 || bus_busy_out !== 1'b0) begin
        bad++;
        $display("FAIL abort cyc=%0d rdn=%b dout=%h busy=%b required 0 0 0", i, read_dn, data_out, bus_busy_out);
      end
    end
    do_read(8'h10, 0);
  endtask

  task automatic test_reset_mid_read();
    int n;
    addr_in = 32'h20;
    read_q  = 1'b1;
    n = 0;
    tick();
    while (read_dn !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    #2 rst_b = 1'b0;
    #1;
    total++;
    if (read_dn !== 1'b0 || data_out !== 32'h0 || bus_busy_out !== 1'b0 || n >= 20) begin
      bad++;
      $display("FAIL rst_async rdn=%b dout=%h busy=%b wait=%0d required 0 0 0 and read_dn seen", read_dn, data_out, bus_busy_out, n);
    end
    read_q = 1'b0;
    tick();
    rst_b = 1'b1;
    tick();
    do_read(8'h20, 0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      do_write(8'h30 + 8'(i), d, 1'b0, 0);
    end
    for (int i = 0; i < 4; i++) do_read(8'h30 + 8'(i), 0);
  endtask

  task automatic test_random();
    logic [7:0]  off;
    logic [23:0] hi;
    int op;
    for (int k = 0; k < 40; k++) begin
      op = $urandom_range(0, 3);
      if (op == 0 || op == 1) begin
        off = 8'($urandom_range(0, 254));
        do_write(off, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      end else if (op == 2) begin
        do begin
          off = 8'($urandom_range(0, 254));
        end while (!written[off]);
        do_read(off, $urandom_range(0, 3));
      end else begin
        hi = 24'($urandom_range(1, 24'hFFFFFF));
        addr_in = {hi, 8'($urandom_range(0, 255))};
        data_in = $urandom;
        read_q  = 1'($urandom_range(0, 1));
        write_q = 1'b1;
        for (int i = 0; i < 3; i++) begin
          tick();
          total++;
          if ({data_out, read_dn, write_dn, bus_busy_out} !== 35'h0) begin
            bad++;
            $display("FAIL rand_nohit addr=%h dout=%h rdn=%b wdn=%b busy=%b required all 0", addr_in, data_out, read_dn, write_dn, bus_busy_out);
          end
        end
        read_q  = 1'b0;
        write_q = 1'b0;
        tick();
      end
    end
  endtask

`ifdef WRITE_PROTECT_EN
  task automatic test_write_protect();
    do_write(8'h3F, 32'hAAAA_5555, 1'b0, 0);
    addr_unmodificable_b = 32'h40;
    do_write(8'h3F, 32'h1234, 1'b0, 1);
    do_read(8'h3F, 0);
    do_read(8'hFF, 0);
    do_write(8'h40, 32'h1234, 1'b0, 0);
    do_read(8'h40, 0);
    addr_unmodificable_b = 32'h0;
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) written[i] = 1'b0;
    rst_b = 1'b0;
    test_reset();
    test_write_read();
    test_simultaneous();
    test_abort();
    test_reset_mid_read();
    test_back_to_back();
    test_random();
`ifdef WRITE_PROTECT_EN
    test_write_protect();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
